// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and bit-period helpers
package uart_pkg;

    // Transmitter frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // 115200 baud from a 50 MHz clock
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // Width of a counter that must hold 0..clks_per_bit-1
    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

    // Receiver samples each bit at its centre, this many cycles in
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with terminal-count pulse
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int ClksPerBit = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CntW = cnt_width(ClksPerBit);
    localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] cnt;

    // A clear cycle never reports a finished bit, so the first period after
    // a clear is always a full ClksPerBit cycles long
    assign bit_done = (cnt == LastCnt) && !clear;

    // Count 0..ClksPerBit-1 and wrap, restarting from 0 whenever cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LastCnt) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serialiser fed from a FIFO read port
module uart_tx
    import uart_pkg::*;
#(
    parameter int DataWidth  = 8,
    parameter int ClksPerBit = 434,
    parameter int ParityEn   = 0,
    parameter int ParityOdd  = 0,
    parameter int StopBits   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DataWidth-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int IdxW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DataWidth - 1);
    localparam logic StopLast = (StopBits == 2);
    localparam logic OddSel = (ParityOdd != 0);
    localparam logic ParityOn = (ParityEn != 0);

    tx_state_t            state;
    logic [DataWidth-1:0] shreg;
    logic [IdxW-1:0]      bit_idx;
    logic                 stop_idx;
    logic                 parity;
    logic                 tx_q;
    logic                 accept;
    logic                 bit_done;
    logic                 baud_clear;

    // o_ready doubles as the FIFO pop, so it is held low while reset is applied
    assign o_ready    = (state == ST_IDLE) && !i_rst;
    assign accept     = i_valid && o_ready;
    assign o_busy     = (state != ST_IDLE);
    assign o_tx       = tx_q;

    // Holding the counter clear through IDLE also clears it on the accept edge
    assign baud_clear = (state == ST_IDLE);

    uart_baud_cnt #(
        .ClksPerBit(ClksPerBit)
    ) u_baud (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (baud_clear),
        .bit_done (bit_done)
    );

    // Frame sequencer; o_tx is registered and loaded one edge ahead of each bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            tx_q     <= 1'b1;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            parity   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (accept) begin
                        shreg    <= i_data;
                        parity   <= (^i_data) ^ OddSel;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        tx_q     <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        tx_q  <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LastIdx) begin
                            if (ParityOn) begin
                                tx_q  <= parity;
                                state <= ST_PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + IdxW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        tx_q  <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (stop_idx == StopLast) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx in three framing configurations
module tb_uart_tx;

    localparam int C = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       par;
        logic       abort;
        logic       chk_gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [3];
    logic [2:0] vin;
    logic [2:0] txs;
    logic [2:0] rdys;
    logic [2:0] busys;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Lane 0: no parity, 1 stop. Lane 1: even parity, 2 stop. Lane 2: odd parity, 1 stop.
    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int PE = (g == 0) ? 0 : 1;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g == 1) ? 2 : 1;
        localparam int NB = 1 + 8 + PE + SB;

        exp_t exp_q[$];

        uart_tx #(
            .DataWidth (8),
            .ClksPerBit(C),
            .ParityEn  (PE),
            .ParityOdd (PO),
            .StopBits  (SB)
        ) dut (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_data (din[g]),
            .i_valid(vin[g]),
            .o_ready(rdys[g]),
            .o_tx   (txs[g]),
            .o_busy (busys[g])
        );

        initial begin : mon
            logic samp[$];
            int   idle_cyc;
            int   gap;
            int   rdy_bad;
            int   bit_bad;
            int   b;
            bit   aborted;
            exp_t e;
            logic eb;
            idle_cyc = 0;
            forever begin
                @(negedge clk);
                if (rst !== 1'b0 || txs[g] !== 1'b0) continue;
                gap = cyc - idle_cyc;
                samp.delete();
                rdy_bad = 0;
                aborted = 1'b0;
                while (busys[g] === 1'b1 && samp.size() < 400) begin
                    samp.push_back(txs[g]);
                    if (rdys[g] !== 1'b0) rdy_bad++;
                    @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL lane%0d_unexpected_frame: got frame of %0d cycles, required none", g, samp.size());
                    continue;
                end
                e = exp_q.pop_front();
                check($sformatf("lane%0d_abort", g), aborted, e.abort);
                if (aborted) begin
                    check($sformatf("lane%0d_tx_high_in_reset", g), txs[g], 1);
                    check($sformatf("lane%0d_busy_low_in_reset", g), busys[g], 0);
                    continue;
                end
                idle_cyc = cyc;
                check($sformatf("lane%0d_frame_len_%02h", g, e.d), samp.size(), NB * C);
                bit_bad = 0;
                for (int i = 0; i < samp.size(); i++) begin
                    b = i / C;
                    if (b == 0) eb = 1'b0;
                    else if (b <= 8) eb = e.d[b-1];
                    else if (PE != 0 && b == 9) eb = e.par;
                    else eb = 1'b1;
                    if (samp[i] !== eb) bit_bad++;
                end
                check($sformatf("lane%0d_bad_bit_cycles_%02h", g, e.d), bit_bad, 0);
                check($sformatf("lane%0d_ready_in_frame", g), rdy_bad, 0);
                check($sformatf("lane%0d_idle_tx", g), txs[g], 1);
                check($sformatf("lane%0d_idle_ready", g), rdys[g], 1);
                if (e.chk_gap) check($sformatf("lane%0d_b2b_gap", g), gap, 1);
            end
        end
    end

    function automatic exp_t mk(input logic [7:0] d, input int odd, input bit ab, input bit gp);
        exp_t e;
        e.d       = d;
        e.par     = ((($countones(d) + odd) % 2) == 1);
        e.abort   = ab;
        e.chk_gap = gp;
        return e;
    endfunction

    task automatic push(input int l, input exp_t e);
        case (l)
            0:       lane[0].exp_q.push_back(e);
            1:       lane[1].exp_q.push_back(e);
            default: lane[2].exp_q.push_back(e);
        endcase
    endtask

    // Offer a byte and return 1 ns after the edge that accepted it
    task automatic xfer(input int l, input logic [7:0] d, input bit hold, input bit ab, input bit gp);
        int n;
        n = 0;
        din[l] = d;
        vin[l] = 1'b1;
        push(l, mk(d, (l == 2) ? 1 : 0, ab, gp));
        while (rdys[l] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("lane%0d_accept_in_time", l), (n < 200), 1);
        @(posedge clk);
        #1;
        if (!hold) vin[l] = 1'b0;
    endtask

    task automatic rand_lane(input int l);
        bit h;
        bit prev_h;
        prev_h = 1'b0;
        for (int k = 0; k < 5; k++) begin
            h = (k < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            xfer(l, 8'($urandom), h, 1'b0, prev_h);
            if (!h) repeat ($urandom_range(0, 6)) @(negedge clk);
            prev_h = h;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busys != 3'b000 || lane[0].exp_q.size() != 0 || lane[1].exp_q.size() != 0 ||
                lane[2].exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_in_time", (n < 3000), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vin = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("lane%0d_reset_tx", l), txs[l], 1);
            check($sformatf("lane%0d_reset_busy", l), busys[l], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int l = 0; l < 3; l++) check($sformatf("lane%0d_ready_after_reset", l), rdys[l], 1);

        fork
            begin
                xfer(0, 8'hA5, 1'b0, 1'b0, 1'b0);
                repeat (50) @(negedge clk);
                xfer(0, 8'h00, 1'b1, 1'b0, 1'b0);
                xfer(0, 8'hFF, 1'b0, 1'b0, 1'b1);
                repeat (50) @(negedge clk);
                xfer(0, 8'h3C, 1'b0, 1'b0, 1'b0);
                repeat (16) begin
                    @(posedge clk);
                    #1 din[0] = 8'($urandom);
                end
                xfer(0, 8'h5A, 1'b0, 1'b0, 1'b1);
                rand_lane(0);
            end
            begin
                xfer(1, 8'h07, 1'b1, 1'b0, 1'b0);
                xfer(1, 8'($urandom), 1'b0, 1'b0, 1'b1);
                rand_lane(1);
            end
            begin
                xfer(2, 8'h07, 1'b0, 1'b0, 1'b0);
                rand_lane(2);
            end
        join
        drain();

        xfer(0, 8'($urandom), 1'b0, 1'b1, 1'b0);
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("tx_high_on_reset_assert", txs[0], 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        din[0] = 8'h81;
        vin[0] = 1'b1;
        push(0, mk(8'h81, 0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check("accept_first_edge_after_reset", busys[0], 1);
        vin[0] = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
